// File: rtl/lut_and_i8_skid_stage.sv
// lut_and_i8_skid_stage
//   Output stage for the LUT-mapped 8-bit AND. Captures y under a valid/ready
//   handshake into a 2-entry skid buffer (head + skid registers), so that
//   in_ready and out_valid are decoded from registered state only and
//   downstream back-pressure never reaches the AND datapath combinationally.
//   Also counts completed output transfers in a wrapping counter.
//   Optional feature: define AND_SKID_PARITY_EN to add out_parity (= ^out_y),
//   registered alongside the head register.
module lut_and_i8_skid_stage #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_y,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] xfer_count
`ifdef AND_SKID_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_head;
  logic [WIDTH-1:0]     r_skid;
  logic [WIDTH-1:0]     w_head_nxt;
  logic [WIDTH-1:0]     w_skid_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_push;
  logic                 w_pop;

  // Handshake flags are decoded from the state register only.
  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign out_y      = r_head;
  assign xfer_count = r_cnt;

  // Next-state and next-data decode for the skid buffer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
          w_head_nxt  = in_y;
        end
      end
      ST_ONE: begin
        unique case ({w_push, w_pop})
          2'b11: w_head_nxt = in_y;
          2'b10: begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = in_y;
          end
          2'b01: w_state_nxt = ST_EMPTY;
          default: ;
        endcase
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt = ST_ONE;
          w_head_nxt  = r_skid;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State and storage registers; reset drops any buffered data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the data registers are reset too (not just the state), because
      // out_y is architecturally visible and must read 0 out of reset.
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Completed output handshakes; wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef AND_SKID_PARITY_EN
  logic r_parity;

  // Parity of the head register, loaded in the same cycle as the head itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_head_nxt;
    end
  end

  assign out_parity = r_parity;
`endif

endmodule
